alu_4bit_seq: RTL and testbench

Registered, handshaked 4-bit signed ALU. It is the responder that accepts operand/opcode transactions and returns a result with status flags. Single-cycle logic ops and add/sub, plus a multi-cycle shift-add signed multiply. It sits between the operand sequencer and the result consumer of the 4-bit ALU datapath, replacing the bare combinational unit blocks.

---
 rtl/alu_4bit_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_4bit_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_4bit_seq.sv
// Handshaked signed ALU: single-cycle logic/add/sub/not, multi-cycle shift-add multiply.
// One transaction in flight at a time; result and flags are held until the consumer takes them.
module alu_4bit_seq #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic signed [WIDTH-1:0] in1,
  input  logic signed [WIDTH-1:0] in2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    zero,
  output logic                    neg,
  output logic                    ovf,
  output logic                    err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    accept;

  logic [PW-1:0]           mcand_p0;
  logic [WIDTH-1:0]        mplier_p0;
  logic [PW-1:0]           acc_p0;
  logic                    sign_p0;

  logic signed [WIDTH-1:0] sum_c;
  logic signed [WIDTH-1:0] diff_c;
  logic signed [WIDTH-1:0] alu_res;
  logic                    alu_ovf;
  logic                    alu_err;
  logic [PW-1:0]           acc_nxt;
  logic signed [PW-1:0]    prod;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] m;
    m = x[WIDTH-1] ? -x : x;
    return m;
  endfunction

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Product fits in WIDTH bits only if the upper half plus the result sign bit agree.
  function automatic logic mul_ovf(input logic signed [PW-1:0] p);
    return !((&p[PW-1:WIDTH-1]) || !(|p[PW-1:WIDTH-1]));
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign sum_c    = in1 + in2;
  assign diff_c   = in1 - in2;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_AND: alu_res = in1 & in2;
      OP_OR:  alu_res = in1 | in2;
      OP_XOR: alu_res = in1 ^ in2;
      OP_ADD: begin
        alu_res = sum_c;
        alu_ovf = add_ovf(in1, in2, sum_c);
      end
      OP_SUB: begin
        alu_res = diff_c;
        alu_ovf = sub_ovf(in1, in2, diff_c);
      end
      OP_NOT: alu_res = ~in1;
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_nxt = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  assign prod    = sign_p0 ? -$signed(acc_nxt) : $signed(acc_nxt);

  // Stage p0: operand magnitudes captured at accept, then shifted once per MUL cycle
  always_ff @(posedge clk) begin
    if (accept && op == OP_MUL) begin
      mcand_p0  <= {{WIDTH{1'b0}}, mag(in1)};
      mplier_p0 <= mag(in2);
      acc_p0    <= '0;
      sign_p0   <= in1[WIDTH-1] ^ in2[WIDTH-1];
    end else if (state == MUL) begin
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      acc_p0    <= acc_nxt;
    end
  end

  // Output stage: result/flags registered on completion, held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state <= MUL;
              cnt   <= '0;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              neg       <= alu_res[WIDTH-1];
              ovf       <= alu_ovf;
              err       <= alu_err;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            result    <= prod[WIDTH-1:0];
            zero      <= (prod[WIDTH-1:0] == '0);
            neg       <= prod[WIDTH-1];
            ovf       <= mul_ovf(prod);
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_4bit_seq.sv
// Scoreboard bench for alu_4bit_seq: directed cases, backpressure, async reset, then random traffic
// checked against an integer-arithmetic reference model.
module tb_alu_4bit_seq;

  localparam int W    = 4;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         neg;
  logic         ovf;
  logic         err;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         o;
    logic         e;
    int           lat;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   seen   = 1'b0;
  int   rdy_mode = 0;
  logic rnd_rdy  = 1'b1;

  alu_4bit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_rdy = 1'($urandom_range(0, 1));
  assign out_ready = (rdy_mode == 0) || (rdy_mode == 1 && rnd_rdy);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ia;
    int   ib;
    int   full;
    ia   = int'($signed(a));
    ib   = int'($signed(b));
    full = 0;
    e.o  = 1'b0;
    e.e  = 1'b0;
    e.lat = 1;
    e.cyc = 0;
    case (o)
      3'd0: e.r = a & b;
      3'd1: e.r = a | b;
      3'd2: e.r = a ^ b;
      3'd3: full = ia + ib;
      3'd4: full = ia - ib;
      3'd5: begin
        full  = ia * ib;
        e.lat = W + 1;
      end
      3'd6: e.r = ~a;
      default: begin
        e.r = '0;
        e.e = 1'b1;
      end
    endcase
    if (o == 3'd3 || o == 3'd4 || o == 3'd5) begin
      e.r = full[W-1:0];
      e.o = (full > MAXV) || (full < MINV);
    end
    e.z = (e.r == '0);
    e.n = e.r[W-1];
    return e;
  endfunction

  // Monitor: pop one expectation per presented result, then check it stays put while held
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: result %0h with no transaction outstanding", result);
        end else begin
          cur = sb.pop_front();
          chk("result_flags", {24'd0, result, zero, neg, ovf, err},
              {24'd0, cur.r, cur.z, cur.n, cur.o, cur.e});
          chk("latency_cycle", cyc, cur.cyc);
        end
      end else begin
        chk("hold_stable", {24'd0, result, zero, neg, ovf, err},
            {24'd0, cur.r, cur.z, cur.n, cur.o, cur.e});
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   k;
    @(negedge clk);
    op       = o;
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    k        = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    e     = model(o, a, b);
    e.cyc = cyc + e.lat;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    op       = 3'($urandom);
    in1      = W'($urandom);
    in2      = W'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      k++;
    end
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: in_ready still 0, expected 1 after hand-off");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = '0;
    in1      = '0;
    in2      = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_result_flags", {24'd0, result, zero, neg, ovf, err}, 32'd0);
    rst_n = 1'b1;

    issue(3'd2, 4'b1111, 4'b1111); wait_done();
    issue(3'd2, 4'b1011, 4'b0011); wait_done();
    issue(3'd3, 4'b0111, 4'b0001); wait_done();
    issue(3'd4, 4'b1000, 4'b0001); wait_done();
    issue(3'd3, 4'b1111, 4'b0001); wait_done();
    issue(3'd5, 4'b1110, 4'b0011); wait_done();
    issue(3'd5, 4'b0100, 4'b0100); wait_done();
    issue(3'd5, 4'b1000, 4'b1111); wait_done();
    issue(3'd7, 4'b0101, 4'b0000); wait_done();
    issue(3'd0, 4'b1100, 4'b1010); wait_done();
    issue(3'd6, 4'b0110, 4'b0000); wait_done();

    // Backpressure: result held while a competing request waits unaccepted
    rdy_mode = 2;
    issue(3'd2, 4'b1100, 4'b0101);
    in_valid = 1'b1;
    op       = 3'd3;
    in1      = 4'b0001;
    in2      = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset two cycles into a multiply
    issue(3'd5, 4'b0011, 4'b0011);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_mul_reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_mul_reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_mul_reset_result", {24'd0, result, zero, neg, ovf, err}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd1, 4'b0001, 4'b0010); wait_done();

    // Random traffic with random consumer backpressure
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end
    rdy_mode = 0;
    for (int k = 0; k < 100 && (sb.size() != 0 || out_valid); k++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
